// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared FSM encoding and defaults for the UART TX feeder
// FSM state constants, default byte width and a pointer-width helper.
package uart_tx_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  // Pointer width carries one extra wrap bit above the address bits.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous byte FIFO with wrap-bit pointers
// Full/empty/count are decoded combinationally from the registered pointers.
module uart_sync_fifo
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    WR_EN,
  input  logic [DATA_WIDTH-1:0]   WR_DATA,
  input  logic                    RD_EN,
  output logic [DATA_WIDTH-1:0]   RD_DATA,
  output logic                    FULL,
  output logic                    EMPTY,
  output logic [$clog2(DEPTH):0]  FIFO_COUNT,
  output logic                    OVERFLOW
);

  localparam int AW = ptr_width(DEPTH) - 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_sync_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  do_write;
  logic                  do_read;

  // Same address with differing wrap bits means the writer lapped the reader.
  assign FULL       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign EMPTY      = (wr_ptr == rd_ptr);
  assign FIFO_COUNT = wr_ptr - rd_ptr;

  // FULL is judged before any same-cycle pop, so a push while full is lost.
  assign do_write = WR_EN && !FULL;
  assign do_read  = RD_EN && !EMPTY;

  assign RD_DATA = mem[rd_ptr[AW-1:0]];

  // Storage array; intentionally not cleared by reset.
  always_ff @(posedge CLK) begin
    if (do_write) begin
      mem[wr_ptr[AW-1:0]] <= WR_DATA;
    end
  end

  // Write pointer advances on each accepted push.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
    end else if (do_write) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // Read pointer advances on each pop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr <= '0;
    end else if (do_read) begin
      rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // One-cycle flag for a push attempted against a full FIFO.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OVERFLOW <= 1'b0;
    end else begin
      OVERFLOW <= WR_EN && FULL;
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - FIFO-buffered byte feeder for the UART TX path
// Optional Busy-rise timeout with TX_TIMEOUT output under UART_TX_FEEDER_TIMEOUT_EN.
module uart_tx_feeder
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   WR_DATA,
  input  logic                    WR_EN,
  output logic                    FULL,
  output logic                    EMPTY,
  output logic                    OVERFLOW,
  output logic [$clog2(DEPTH):0]  FIFO_COUNT,
  input  logic                    Busy,
  output logic                    Data_Valid,
  output logic [DATA_WIDTH-1:0]   P_DATA
`ifdef UART_TX_FEEDER_TIMEOUT_EN
  ,
  output logic                    TX_TIMEOUT
`endif
);

  // Busy rises two cycles after Data_Valid, so a shorter window always fires.
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("uart_tx_feeder: TIMEOUT_CYCLES must be at least 2");
  end

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .CLK        (CLK),
    .RST        (RST),
    .WR_EN      (WR_EN),
    .WR_DATA    (WR_DATA),
    .RD_EN      (rd_en),
    .RD_DATA    (rd_data),
    .FULL       (FULL),
    .EMPTY      (EMPTY),
    .FIFO_COUNT (FIFO_COUNT),
    .OVERFLOW   (OVERFLOW)
  );

`ifdef UART_TX_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
`endif

  // Issue only from IDLE with Busy low, so a frame is never overlapped;
  // after reset this also holds off until a running frame's Busy drops.
  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    tmo_hit    = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (!EMPTY && !Busy) begin
          rd_en      = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (Busy) begin
          state_next = ST_WAIT_DONE;
        end
`ifdef UART_TX_FEEDER_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          tmo_hit    = 1'b1;
          state_next = ST_IDLE;
        end
`endif
      end
      ST_WAIT_DONE: begin
        if (!Busy) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Byte is captured at the pop and held until the next issue.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      P_DATA <= '0;
    end else if (rd_en) begin
      P_DATA <= rd_data;
    end
  end

  assign Data_Valid = (state == ST_ISSUE);

`ifdef UART_TX_FEEDER_TIMEOUT_EN
  // Counts cycles spent in WAIT_BUSY; cleared whenever the FSM leaves it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tmo_cnt <= '0;
    end else if (state == ST_WAIT_BUSY && state_next == ST_WAIT_BUSY) begin
      tmo_cnt <= tmo_cnt + TMO_ONE;
    end else begin
      tmo_cnt <= '0;
    end
  end

  // One-cycle pulse when Busy never rose; the issued byte is abandoned.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      TX_TIMEOUT <= 1'b0;
    end else begin
      TX_TIMEOUT <= tmo_hit;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - self-checking bench for uart_tx_feeder
// TX_TIMEOUT steps run only when UART_TX_FEEDER_TIMEOUT_EN is defined.
module tb_uart_tx_feeder;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int TMO   = 4;
  localparam int FRAME = 11;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic          WR_EN;
  logic [DW-1:0] WR_DATA;
  logic          FULL;
  logic          EMPTY;
  logic          OVERFLOW;
  logic [CW-1:0] FIFO_COUNT;
  logic          Busy;
  logic          Data_Valid;
  logic [DW-1:0] P_DATA;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
  logic          TX_TIMEOUT;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference: bytes accepted and not yet presented to TX, in order.
  logic [DW-1:0] exp_q[$];

  bit busy_manual_en = 1'b1;
  bit busy_manual    = 1'b0;
  bit rand_frames    = 1'b0;
  int busy_start     = -100;
  int cur_frame      = 0;
  int last_dv        = 0;
  int last_frame     = 0;
  bit last_dv_auto   = 1'b0;
  int n_issued       = 0;

  uart_tx_feeder #(
    .DATA_WIDTH     (DW),
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .WR_DATA    (WR_DATA),
    .WR_EN      (WR_EN),
    .FULL       (FULL),
    .EMPTY      (EMPTY),
    .OVERFLOW   (OVERFLOW),
    .FIFO_COUNT (FIFO_COUNT),
    .Busy       (Busy),
    .Data_Valid (Data_Valid),
    .P_DATA     (P_DATA)
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    ,
    .TX_TIMEOUT (TX_TIMEOUT)
`endif
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    WR_EN   = 1'b1;
    WR_DATA = d;
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    step();
    WR_EN = 1'b0;
  endtask

  task automatic wait_dv(input int maxc, output int at);
    int n;
    n = 0;
    while (Data_Valid !== 1'b1 && n < maxc) begin
      step();
      n++;
    end
    check("dv_seen", Data_Valid, 1);
    at = cyc;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && Busy == 1'b0 && cyc >= busy_start + cur_frame + 2) && n < 400) begin
      step();
      n++;
    end
    check("idle_reached", n < 400, 1);
    repeat (2) step();
  endtask

  // TX model: Busy goes high 2 cycles after each Data_Valid for one frame,
  // and every presented byte is checked against the reference queue.
  initial begin
    Busy = 1'b0;
    forever begin
      @(posedge CLK);
      #2;
      if (busy_manual_en) Busy = busy_manual;
      else Busy = (cyc >= busy_start) && (cyc < busy_start + cur_frame);
      if (Data_Valid === 1'b1) begin
        n_issued++;
        check("dv_while_busy", Busy, 0);
        check("issue_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("issue_data", P_DATA, exp_q.pop_front());
        if (!busy_manual_en) begin
          if (last_dv_auto) check("dv_spacing", (cyc - last_dv) >= (last_frame + 3), 1);
          cur_frame    = rand_frames ? int'($urandom_range(3, 12)) : FRAME;
          busy_start   = cyc + 2;
          last_dv      = cyc;
          last_frame   = cur_frame;
          last_dv_auto = 1'b1;
        end else begin
          last_dv_auto = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int at;
    int t0;
    int base;

    RST     = 1'b1;
    WR_EN   = 1'b0;
    WR_DATA = '0;
    repeat (3) step();
    check("rst_dv", Data_Valid, 0);
    check("rst_pdata", P_DATA, 0);
    check("rst_empty", EMPTY, 1);
    check("rst_full", FULL, 0);
    check("rst_overflow", OVERFLOW, 0);
    check("rst_count", FIFO_COUNT, 0);
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    check("rst_timeout", TX_TIMEOUT, 0);
`endif
    RST            = 1'b0;
    busy_manual_en = 1'b0;
    step();

    // Reset during WAIT_DONE with three bytes queued.
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    n = 0;
    while (Busy !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("t1_busy_rose", Busy, 1);
    repeat (2) step();
    check("t1_count_before_rst", FIFO_COUNT, 3);
    RST = 1'b1;
    #2;
    check("t1_rst_dv", Data_Valid, 0);
    check("t1_rst_pdata", P_DATA, 0);
    check("t1_rst_empty", EMPTY, 1);
    check("t1_rst_count", FIFO_COUNT, 0);
    exp_q.delete();
    step();
    RST = 1'b0;
    check("t1_busy_still_high", Busy, 1);
    push(8'h55);
    wait_dv(40, at);
    check("t1_issue_after_busy_low", at >= busy_start + cur_frame, 1);
    wait_idle();

    // Single byte latency and frame spacing.
    check("t2_empty_start", EMPTY, 1);
    t0 = cyc;
    push(8'hA5);
    check("t2_dv_c1", Data_Valid, 0);
    step();
    check("t2_dv_c2", Data_Valid, 1);
    check("t2_pdata_c2", P_DATA, 8'hA5);
    step();
    check("t2_dv_c3", Data_Valid, 0);
    push(8'h5A);
    check("t2_pdata_held", P_DATA, 8'hA5);
    wait_dv(40, at);
    check("t2_next_not_before_16", at >= t0 + 16, 1);
    check("t2_next_pdata", P_DATA, 8'h5A);
    wait_idle();

    // Burst fill to FULL, then overflow.
    busy_manual    = 1'b1;
    busy_manual_en = 1'b1;
    step();
    for (int i = 1; i <= 8; i++) push(8'(i));
    check("t3_full", FULL, 1);
    check("t3_count", FIFO_COUNT, 8);
    check("t3_not_empty", EMPTY, 0);
    push(8'hFF);
    check("t4_overflow_pulse", OVERFLOW, 1);
    check("t4_count_held", FIFO_COUNT, 8);
    step();
    check("t4_overflow_clear", OVERFLOW, 0);
    check("t4_still_full", FULL, 1);
    base           = n_issued;
    busy_manual_en = 1'b0;
    wait_idle();
    check("t3_issue_count", n_issued - base, 8);
    check("t3_drained", EMPTY, 1);

    // Push and pop in the same cycle.
    busy_manual    = 1'b1;
    busy_manual_en = 1'b1;
    step();
    push(8'h31);
    push(8'h32);
    push(8'h33);
    check("t5_count_before", FIFO_COUNT, 3);
    busy_manual = 1'b0;
    push(8'h34);
    check("t5_count_push_pop", FIFO_COUNT, 3);
    check("t5_dv", Data_Valid, 1);
    busy_manual_en = 1'b0;
    wait_idle();
    check("t5_drained", FIFO_COUNT, 0);

`ifdef UART_TX_FEEDER_TIMEOUT_EN
    // Busy never rises: timeout, byte lost, next byte still issues.
    busy_manual    = 1'b0;
    busy_manual_en = 1'b1;
    step();
    t0 = cyc;
    push(8'h61);
    push(8'h62);
    check("t6_dv_first", Data_Valid, 1);
    repeat (4) step();
    check("t6_timeout_low_c6", TX_TIMEOUT, 0);
    step();
    check("t6_timeout_c7", TX_TIMEOUT, 1);
    check("t6_cycle_c7", cyc - t0, 7);
    step();
    check("t6_timeout_clear", TX_TIMEOUT, 0);
    check("t6_dv_second", Data_Valid, 1);
    check("t6_pdata_second", P_DATA, 8'h62);
    repeat (5) step();
    check("t6_timeout_second", TX_TIMEOUT, 1);
    step();
    check("t6_timeout_second_clear", TX_TIMEOUT, 0);
    check("t6_empty", EMPTY, 1);
    busy_manual_en = 1'b0;
    wait_idle();
`endif

    // Randomized traffic with random frame lengths.
    rand_frames = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 2) == 0 && exp_q.size() < DEPTH) begin
        WR_EN   = 1'b1;
        WR_DATA = 8'($urandom);
        exp_q.push_back(WR_DATA);
      end else begin
        WR_EN = 1'b0;
      end
      step();
      check("rnd_no_overflow", OVERFLOW, 0);
    end
    WR_EN = 1'b0;
    wait_idle();
    check("end_empty", EMPTY, 1);
    check("end_count", FIFO_COUNT, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
